// File: rtl/systolic_input_ctrl.sv
// systolic_input_ctrl
// Sequences the per-row input shifters on the systolic array's left edge.
// Each tile runs CLEAR -> LOAD -> STREAM -> DONE:
//   - CLEAR reloads the shifters' per-row delay counters.
//   - LOAD takes ARRAYWIDTH beats from the operand buffer.
//   - STREAM holds out_en for the whole skewed drain window.
//   - DONE pulses done for one cycle and counts the tile.
// abort cancels a tile from any busy state: the shifters are cleared and the
// tile is not counted.
//
// Handshake: a beat transfers in every cycle where in_valid and in_ready are
// both high. in_ready is high only in LOAD and only when abort is low. The
// source may raise or drop in_valid at any time; a low in_valid in LOAD
// stalls the tile by exactly one cycle. The shifters' load_en is that
// transfer strobe and nothing else.

module systolic_input_ctrl #(
  parameter int ARRAYWIDTH = 4,
  parameter int DSP_DELAY  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        sh_clr,
  output logic        sh_load_en,
  output logic        sh_out_en,
  output logic [7:0]  beat_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] tile_cnt,
  output logic [2:0]  state_dbg
);

  // Drain window: the last row is skewed by (DSP_DELAY-1)*(ARRAYWIDTH-1)
  // cycles, and a full diagonal needs another 2*ARRAYWIDTH-1 cycles to pass
  // through the array.
  localparam int DRAIN = (2 * ARRAYWIDTH - 1) + (DSP_DELAY - 1) * (ARRAYWIDTH - 1);

  // The counter starts at DRAIN-1 and counts down to 0, so STREAM lasts
  // exactly DRAIN cycles.
  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN - 1);
  localparam logic [7:0] LAST_BEAT  = 8'(ARRAYWIDTH - 1);

  // The drain counter is 8 bits; a larger window cannot be represented.
  generate
    if (DRAIN > 255 || DRAIN < 1) begin : g_drain_range_check
      $error("systolic_input_ctrl: DRAIN out of range for the 8-bit drain counter");
    end
    if (ARRAYWIDTH < 1 || ARRAYWIDTH > 256) begin : g_width_range_check
      $error("systolic_input_ctrl: ARRAYWIDTH must be in 1..256 for the 8-bit beat index");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] drain_cnt;

  // State machine, beat index, drain counter and completed-tile counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      beat_idx  <= 8'd0;
      drain_cnt <= 8'd0;
      tile_cnt  <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // abort has no meaning in IDLE, so start always wins here.
          if (start) begin
            state <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          if (abort) begin
            state    <= S_ABORT;
            beat_idx <= 8'd0;
          end else begin
            state    <= S_LOAD;
            beat_idx <= 8'd0;
          end
        end

        S_LOAD: begin
          if (abort) begin
            state    <= S_ABORT;
            beat_idx <= 8'd0;
          end else if (in_valid) begin
            if (beat_idx == LAST_BEAT) begin
              // Last beat taken: the index returns to 0 so it always names
              // the next beat, and the drain window begins.
              state     <= S_STREAM;
              beat_idx  <= 8'd0;
              drain_cnt <= DRAIN_INIT;
            end else begin
              beat_idx <= beat_idx + 8'd1;
            end
          end
        end

        S_STREAM: begin
          if (abort) begin
            state     <= S_ABORT;
            drain_cnt <= 8'd0;
          end else if (drain_cnt == 8'd0) begin
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end

        S_DONE: begin
          // A late abort still cancels the tile: no done, no count.
          if (abort) begin
            state <= S_ABORT;
          end else begin
            state    <= S_IDLE;
            tile_cnt <= tile_cnt + 16'd1;
          end
        end

        S_ABORT: begin
          state     <= S_IDLE;
          beat_idx  <= 8'd0;
          drain_cnt <= 8'd0;
        end

        default: begin
          state     <= S_IDLE;
          beat_idx  <= 8'd0;
          drain_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Output decode from the current state. abort suppresses the shifter
  // strobes and done in the same cycle, so a cancelled tile moves no data.
  always_comb begin
    in_ready   = 1'b0;
    sh_clr     = 1'b0;
    sh_load_en = 1'b0;
    sh_out_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_CLEAR: begin
        busy   = 1'b1;
        sh_clr = 1'b1;
      end
      S_LOAD: begin
        busy       = 1'b1;
        in_ready   = ~abort;
        sh_load_en = in_valid & ~abort;
      end
      S_STREAM: begin
        busy      = 1'b1;
        sh_out_en = ~abort;
      end
      S_DONE: begin
        busy = 1'b1;
        done = ~abort;
      end
      S_ABORT: begin
        busy   = 1'b1;
        sh_clr = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule
